// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall generation.
// Optional define FWD_HAZARD_CNT_EN adds saturating stall/forward event counters.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o
`ifdef FWD_HAZARD_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       fwd_cnt_o
`endif
);
    logic              idex_valid_q, idex_regwrite_q, idex_memread_q;
    logic [REG_AW-1:0] idex_rs1_q, idex_rs2_q, idex_rd_q;
    logic              exmem_valid_q, exmem_regwrite_q;
    logic [REG_AW-1:0] exmem_rd_q;
    logic              memwb_valid_q, memwb_regwrite_q;
    logic [REG_AW-1:0] memwb_rd_q;
    logic              idex_valid_d, idex_regwrite_d, idex_memread_d;
    logic [REG_AW-1:0] idex_rs1_d, idex_rs2_d, idex_rd_d;
    logic              exmem_wr, memwb_wr;

    assign stall_o = idex_valid_q && idex_memread_q && (idex_rd_q != '0) && id_valid_i && !flush_i
                     && ((idex_rd_q == id_rs1_i) || (idex_rd_q == id_rs2_i));

    // A squashed, stalled or invalid ID slot enters ID/EX as an all-zero bubble
    always_comb begin
        idex_valid_d    = id_valid_i && !stall_o && !flush_i;
        idex_rs1_d      = idex_valid_d ? id_rs1_i : '0;
        idex_rs2_d      = idex_valid_d ? id_rs2_i : '0;
        idex_rd_d       = idex_valid_d ? id_rd_i : '0;
        idex_regwrite_d = idex_valid_d && id_regwrite_i;
        idex_memread_d  = idex_valid_d && id_memread_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_valid_q     <= 1'b0;
            idex_rs1_q       <= '0;
            idex_rs2_q       <= '0;
            idex_rd_q        <= '0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            exmem_valid_q    <= 1'b0;
            exmem_rd_q       <= '0;
            exmem_regwrite_q <= 1'b0;
            memwb_valid_q    <= 1'b0;
            memwb_rd_q       <= '0;
            memwb_regwrite_q <= 1'b0;
        end else begin
            memwb_valid_q    <= exmem_valid_q;
            memwb_rd_q       <= exmem_rd_q;
            memwb_regwrite_q <= exmem_regwrite_q;
            exmem_valid_q    <= idex_valid_q;
            exmem_rd_q       <= idex_rd_q;
            exmem_regwrite_q <= idex_regwrite_q;
            idex_valid_q     <= idex_valid_d;
            idex_rs1_q       <= idex_rs1_d;
            idex_rs2_q       <= idex_rs2_d;
            idex_rd_q        <= idex_rd_d;
            idex_regwrite_q  <= idex_regwrite_d;
            idex_memread_q   <= idex_memread_d;
        end
    end

    assign exmem_wr = exmem_valid_q && exmem_regwrite_q && (exmem_rd_q != '0);
    assign memwb_wr = memwb_valid_q && memwb_regwrite_q && (memwb_rd_q != '0);

    // EX/MEM checked first: it holds the most recent producer
    always_comb begin
        fwd_a_sel_o = 2'b00;
        fwd_b_sel_o = 2'b00;
        if (idex_valid_q) begin
            fwd_a_sel_o = (exmem_wr && exmem_rd_q == idex_rs1_q) ? 2'b10 :
                          (memwb_wr && memwb_rd_q == idex_rs1_q) ? 2'b01 : 2'b00;
            fwd_b_sel_o = (exmem_wr && exmem_rd_q == idex_rs2_q) ? 2'b10 :
                          (memwb_wr && memwb_rd_q == idex_rs2_q) ? 2'b01 : 2'b00;
        end
    end

`ifdef FWD_HAZARD_CNT_EN
    logic [15:0] stall_cnt_q, fwd_cnt_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_o && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if ((fwd_a_sel_o != 2'b00 || fwd_b_sel_o != 2'b00) && fwd_cnt_q != 16'hFFFF)
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
        end
    end
    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed pipeline scenarios with a queue of expected EX-stage selects.
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [1:0] sel_a, sel_b;
    logic       stall;
    int         ncmp = 0, nerr = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e;
`ifdef FWD_HAZARD_CNT_EN
    logic [15:0] stall_cnt, fwd_cnt;
`endif

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5)) dut (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
        .fwd_a_sel_o(sel_a), .fwd_b_sel_o(sel_b), .stall_o(stall)
`ifdef FWD_HAZARD_CNT_EN
        , .stall_cnt_o(stall_cnt), .fwd_cnt_o(fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one ID slot; es = expected stall now, ea/eb = selects once whatever this cycle
    // captures into ID/EX reaches EX (a bubble when stalled or flushed).
    task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
        @(negedge clk);
        chk({tag, ".stall"}, {15'd0, stall}, {15'd0, es});
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".prev_sel_a"}, {14'd0, sel_a}, {14'd0, e[3:2]});
            chk({tag, ".prev_sel_b"}, {14'd0, sel_b}, {14'd0, e[1:0]});
        end
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    initial begin
        // Reset held with random ID activity
        for (int i = 0; i < 3; i++) begin
            id_valid = 1'b1; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
            id_regwrite = 1'($urandom); id_memread = 1'b1; flush = 1'b0;
            @(negedge clk);
            chk("rst.sel_a", {14'd0, sel_a}, 16'd0);
            chk("rst.sel_b", {14'd0, sel_b}, 16'd0);
            chk("rst.stall", {15'd0, stall}, 16'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nop("post_rst");
        // add x5; add x6,x5,x1
        step("ex_fwd.p", 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        step("ex_fwd.c", 1, 5, 1, 6, 1, 0, 0, 0, 2'b10, 2'b00);
        nop("d1"); nop("d2");
        // add x5; nop; sub x7,x1,x5
        step("wb_fwd.p", 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("wb_fwd.n");
        step("wb_fwd.c", 1, 1, 5, 7, 1, 0, 0, 0, 2'b00, 2'b01);
        nop("d3"); nop("d4");
        // add x5; add x5; or x8,x5,x5
        step("prio.p1", 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        step("prio.p2", 1, 3, 4, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        step("prio.c", 1, 5, 5, 8, 1, 0, 0, 0, 2'b10, 2'b10);
        nop("d5"); nop("d6");
        // lw x9; add x10,x9,x2: one stall then MEM/WB forward
        step("lu.ld", 1, 1, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00);
        step("lu.stall", 1, 9, 2, 10, 1, 0, 0, 1, 2'b00, 2'b00);
        step("lu.c", 1, 9, 2, 10, 1, 0, 0, 0, 2'b01, 2'b00);
`ifdef FWD_HAZARD_CNT_EN
        chk("cnt.stall", stall_cnt, 16'd1);
`endif
        nop("d7"); nop("d8");
        // same pair, consumer flushed
        step("luf.ld", 1, 1, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00);
        step("luf.c", 1, 9, 2, 10, 1, 0, 1, 0, 2'b00, 2'b00);
        nop("d9"); nop("d10");
        // load consumed two slots later: no stall, select 01
        step("ld2.ld", 1, 1, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00);
        nop("ld2.n");
        step("ld2.c", 1, 9, 9, 13, 1, 0, 0, 0, 2'b01, 2'b01);
        nop("d11"); nop("d12");
        // x0 destinations never forward or stall
        step("x0.p", 1, 1, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00);
        step("x0.c", 1, 0, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00);
        step("x0.ld", 1, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("x0.lc", 1, 0, 0, 12, 1, 0, 0, 0, 2'b00, 2'b00);
        nop("d13"); nop("d14");
        // reset mid-stream discards the in-flight producer
        step("mid.p", 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        step("mid.ld", 1, 1, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00);
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs1 = 5'd9; id_rs2 = 5'd5; id_rd = 5'd14; id_regwrite = 1'b1; id_memread = 1'b0;
        #1;
        chk("mid.rst_sel_a", {14'd0, sel_a}, 16'd0);
        chk("mid.rst_stall", {15'd0, stall}, 16'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("mid.c", 1, 5, 9, 14, 1, 0, 0, 0, 2'b00, 2'b00);
`ifdef FWD_HAZARD_CNT_EN
        chk("cnt.stall_rst", stall_cnt, 16'd0);
`endif
        nop("d15"); nop("d16");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
